// File: rtl/tx_filter_pkg.sv
// Shared definitions for the tx_filter FIR shaping block.
// Optional feature: define TX_FILTER_SAT_EN to saturate the rounded result
// to the 16-bit range instead of keeping the low 16 bits (two's-complement wrap).
package tx_filter_pkg;

  localparam int TX_NTAPS = 64;   // default number of taps (power of two)
  localparam int TX_SHIFT = 15;   // default Q-format right shift
  localparam int DATA_W   = 16;   // sample width
  localparam int COEF_W   = 16;   // coefficient width
  localparam int PROD_W   = 32;   // full product width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2
  } tx_state_t;

  // Reduce a rounded, shifted accumulator value to the output sample width.
  function automatic logic signed [DATA_W-1:0] reduce_to_data(input logic signed [63:0] v);
    logic signed [DATA_W-1:0] res;
`ifdef TX_FILTER_SAT_EN
    if (v > 64'sd32767) begin
      res = 16'sh7FFF;
    end else if (v < -64'sd32768) begin
      res = 16'sh8000;
    end else begin
      res = v[DATA_W-1:0];
    end
`else
    res = v[DATA_W-1:0];
`endif
    return res;
  endfunction

endpackage

// File: rtl/tx_filter_mac.sv
// Multiply-accumulate datapath of tx_filter: product, wide accumulator,
// rounding, shift and reduction (saturate or wrap, see TX_FILTER_SAT_EN).
module tx_filter_mac
  import tx_filter_pkg::*;
#(
  parameter int NTAPS = TX_NTAPS,
  parameter int SHIFT = TX_SHIFT
) (
  input  logic                     i_clk,
  input  logic                     i_clr,
  input  logic                     i_acc_clr,
  input  logic                     i_acc_en,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [COEF_W-1:0] i_coef,
  input  logic                     i_round,
  output logic signed [DATA_W-1:0] o_sample
);

  // Accumulator keeps log2(NTAPS) guard bits so a full window never overflows.
  localparam int ACC_W = PROD_W + $clog2(NTAPS);
  localparam logic signed [ACC_W-1:0] RND_C = ACC_W'(64'd1 << (SHIFT - 1));

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_rounded;
  logic signed [ACC_W-1:0]  w_shifted;
  logic signed [DATA_W-1:0] w_reduced;

  logic signed [ACC_W-1:0]  r_acc;
  logic signed [DATA_W-1:0] r_sample;

  assign w_prod    = i_x * i_coef;
  assign w_rounded = r_acc + RND_C;
  assign w_shifted = w_rounded >>> SHIFT;
  assign w_reduced = reduce_to_data(64'(w_shifted));
  assign o_sample  = r_sample;

  // Accumulate products during MAC and latch the rounded result in ROUND.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_acc    <= '0;
      r_sample <= '0;
    end else begin
      if (i_acc_clr) begin
        r_acc <= '0;
      end else if (i_acc_en) begin
        r_acc <= r_acc + ACC_W'(w_prod);
      end
      if (i_round) begin
        r_sample <= w_reduced;
      end
    end
  end

endmodule

// File: rtl/tx_filter.sv
// tx_filter: NTAPS-tap FIR filter for the TX/DAC path. Holds the control FSM,
// circular delay line and pointers; arithmetic lives in tx_filter_mac.
// Optional feature: TX_FILTER_SAT_EN (saturating output, see tx_filter_pkg).
module tx_filter
  import tx_filter_pkg::*;
#(
  parameter int NTAPS = TX_NTAPS,
  parameter int SHIFT = TX_SHIFT
) (
  input  logic                       ctx_clk,
  input  logic                       rtx_rst,
  input  logic                       etx_en,
  input  logic signed [DATA_W-1:0]   isample,
  input  logic                       inew_sample,
  input  logic signed [COEF_W-1:0]   ifilter_coefficient,
  output logic [$clog2(NTAPS)-1:0]   oselect_coefficient,
  output logic signed [DATA_W-1:0]   osample,
  output logic                       osample_ready_trig,
  output logic                       obusy,
  output logic                       ooverrun
);

  localparam int PTR_W = $clog2(NTAPS);
  localparam logic [PTR_W:0] CNT_END  = (PTR_W + 1)'(NTAPS);
  localparam logic [PTR_W:0] CNT_LAST = (PTR_W + 1)'(NTAPS - 1);

  tx_state_t                r_state;
  logic signed [DATA_W-1:0] r_line [NTAPS];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_base;     // slot of the newest sample x[n]
  logic [PTR_W:0]           r_cnt;      // tap index during MAC, runs 0..NTAPS
  logic [PTR_W-1:0]         r_sel;
  logic signed [DATA_W-1:0] r_x;        // x[n-k], aligned with coefficient k
  logic                     r_xv;
  logic                     r_acc_clr;
  logic                     r_trig;
  logic                     r_busy;
  logic                     r_overrun;

  logic [PTR_W-1:0]         w_rd_idx;
  logic                     w_clr;
  logic                     w_round;

  // Disable behaves like reset; reset simply wins when both are active.
  assign w_clr    = rtx_rst | ~etx_en;
  assign w_rd_idx = r_base - r_cnt[PTR_W-1:0];
  assign w_round  = (r_state == ST_ROUND);

  assign oselect_coefficient = r_sel;
  assign osample_ready_trig  = r_trig;
  assign obusy               = r_busy;
  assign ooverrun            = r_overrun;

  // Control FSM, delay line write/read and status flags.
  always_ff @(posedge ctx_clk) begin
    if (w_clr) begin
      r_state   <= ST_IDLE;
      r_wr_ptr  <= '0;
      r_base    <= '0;
      r_cnt     <= '0;
      r_sel     <= '0;
      r_x       <= '0;
      r_xv      <= 1'b0;
      r_acc_clr <= 1'b0;
      r_trig    <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        r_line[i] <= '0;
      end
    end else begin
      r_acc_clr <= 1'b0;
      r_xv      <= 1'b0;
      r_trig    <= 1'b0;
      if (inew_sample && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (inew_sample) begin
            r_line[r_wr_ptr] <= isample;
            r_base           <= r_wr_ptr;
            r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            r_cnt            <= '0;
            r_sel            <= '0;
            r_acc_clr        <= 1'b1;
            r_busy           <= 1'b1;
            r_state          <= ST_MAC;
          end
        end
        ST_MAC: begin
          // Delay line read is registered so x[n-k] meets coefficient k,
          // which arrives one cycle after its address.
          if (r_cnt < CNT_END) begin
            r_x  <= r_line[w_rd_idx];
            r_xv <= 1'b1;
          end
          if (r_cnt == CNT_END) begin
            r_sel   <= '0;
            r_state <= ST_ROUND;
          end else begin
            r_cnt <= r_cnt + (PTR_W + 1)'(1);
            r_sel <= (r_cnt == CNT_LAST) ? '0 : r_sel + PTR_W'(1);
          end
        end
        ST_ROUND: begin
          r_trig  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_sel   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  tx_filter_mac #(
    .NTAPS (NTAPS),
    .SHIFT (SHIFT)
  ) u_mac (
    .i_clk     (ctx_clk),
    .i_clr     (w_clr),
    .i_acc_clr (r_acc_clr),
    .i_acc_en  (r_xv),
    .i_x       (r_x),
    .i_coef    (ifilter_coefficient),
    .i_round   (w_round),
    .o_sample  (osample)
  );

endmodule

// File: tb/tb_tx_filter.sv
// Self-checking bench for tx_filter (NTAPS=64, SHIFT=15) with a scoreboard
// fed by a behavioural FIR model.
module tb_tx_filter;

  localparam int NT = 64;
  localparam int SH = 15;

  logic               ctx_clk = 1'b0;
  logic               rtx_rst = 1'b1;
  logic               etx_en = 1'b1;
  logic signed [15:0] isample = 16'sd0;
  logic               inew_sample = 1'b0;
  logic signed [15:0] ifilter_coefficient;
  logic [5:0]         oselect_coefficient;
  logic signed [15:0] osample;
  logic               osample_ready_trig;
  logic               obusy;
  logic               ooverrun;

  int n_checks = 0;
  int n_fail = 0;
  int trig_cnt = 0;

  logic signed [15:0] coef_mem [NT];
  logic signed [15:0] m_line [NT];
  int                 m_ptr = 0;
  longint             exp_q [$];

  tx_filter dut (
    .ctx_clk             (ctx_clk),
    .rtx_rst             (rtx_rst),
    .etx_en              (etx_en),
    .isample             (isample),
    .inew_sample         (inew_sample),
    .ifilter_coefficient (ifilter_coefficient),
    .oselect_coefficient (oselect_coefficient),
    .osample             (osample),
    .osample_ready_trig  (osample_ready_trig),
    .obusy               (obusy),
    .ooverrun            (ooverrun)
  );

  always #5 ctx_clk = ~ctx_clk;

  // Coefficient ROM with one cycle of read latency.
  always @(posedge ctx_clk) ifilter_coefficient <= coef_mem[oselect_coefficient];

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NT; i++) m_line[i] = 16'sd0;
    m_ptr = 0;
    exp_q.delete();
  endtask

  task automatic push_model(input logic signed [15:0] x);
    longint acc;
    longint r;
    logic signed [15:0] low;
    m_line[m_ptr] = x;
    acc = 0;
    for (int k = 0; k < NT; k++)
      acc += longint'(coef_mem[k]) * longint'(m_line[(m_ptr - k + NT) % NT]);
    m_ptr = (m_ptr + 1) % NT;
    r = (acc + (64'sd1 <<< (SH - 1))) >>> SH;
`ifdef TX_FILTER_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`else
    low = r[15:0];
    r = longint'(low);
`endif
    exp_q.push_back(r);
  endtask

  task automatic set_coefs(input logic signed [15:0] c0, input logic signed [15:0] rest);
    coef_mem[0] = c0;
    for (int i = 1; i < NT; i++) coef_mem[i] = rest;
  endtask

  // Caller sits at a negedge; the sample is presented for exactly one edge.
  task automatic drive_sample(input logic signed [15:0] x, input bit accepted);
    isample = x;
    inew_sample = 1'b1;
    if (accepted) push_model(x);
    @(negedge ctx_clk);
    inew_sample = 1'b0;
  endtask

  task automatic wait_trig(input string tag);
    for (int i = 0; i < 80; i++) begin
      if (osample_ready_trig === 1'b1) return;
      @(negedge ctx_clk);
    end
    check_eq(tag, 64'sd0, 64'sd1);
  endtask

  task automatic send(input logic signed [15:0] x);
    @(negedge ctx_clk);
    drive_sample(x, 1'b1);
    wait_trig("trig_timeout");
  endtask

  task automatic do_reset();
    @(negedge ctx_clk);
    rtx_rst = 1'b1;
    @(negedge ctx_clk);
    rtx_rst = 1'b0;
    model_clear();
  endtask

  // Scoreboard: every output strobe pops one expected value.
  always @(negedge ctx_clk) begin
    if (osample_ready_trig === 1'b1) begin
      trig_cnt++;
      if (exp_q.size() == 0) check_eq("unexpected_trig", 64'sd1, 64'sd0);
      else check_eq("osample", osample, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tc;
    int n1000;
    set_coefs(16'sd32767, 16'sd0);
    model_clear();

    // Reset state
    repeat (3) @(negedge ctx_clk);
    check_eq("rst_busy", obusy, 0);
    check_eq("rst_osample", osample, 0);
    check_eq("rst_trig", osample_ready_trig, 0);
    check_eq("rst_overrun", ooverrun, 0);
    check_eq("rst_sel", oselect_coefficient, 0);
    rtx_rst = 1'b0;

    // Single impulse tap: exact timing of busy, address and strobe
    @(negedge ctx_clk);
    tc = trig_cnt;
    drive_sample(16'sd1000, 1'b1);
    for (int i = 1; i <= 67; i++) begin
      if (i > 1) @(negedge ctx_clk);
      check_eq($sformatf("busy_t%0d", i), obusy, (i <= 66));
      check_eq($sformatf("trig_t%0d", i), osample_ready_trig, (i == 67));
      if (i <= 64) check_eq($sformatf("sel_t%0d", i), oselect_coefficient, i - 1);
      else if (i >= 66) check_eq($sformatf("sel_t%0d", i), oselect_coefficient, 0);
    end
    check_eq("impulse_out", osample, 1000);
    @(negedge ctx_clk);
    check_eq("impulse_trig_once", trig_cnt - tc, 1);
    check_eq("impulse_hold", osample, 1000);

    // Sample while busy is dropped and flags overrun
    do_reset();
    @(negedge ctx_clk);
    tc = trig_cnt;
    drive_sample(16'sd1000, 1'b1);
    repeat (9) @(negedge ctx_clk);
    drive_sample(16'sd5000, 1'b0);
    check_eq("ovr_flag", ooverrun, 1);
    check_eq("ovr_busy", obusy, 1);
    wait_trig("ovr_trig_timeout");
    check_eq("ovr_out", osample, 1000);
    repeat (5) @(negedge ctx_clk);
    check_eq("ovr_trig_once", trig_cnt - tc, 1);

    // Reset mid-MAC aborts the computation
    do_reset();
    @(negedge ctx_clk);
    drive_sample(16'sd1000, 1'b1);
    repeat (19) @(negedge ctx_clk);
    rtx_rst = 1'b1;
    @(negedge ctx_clk);
    rtx_rst = 1'b0;
    model_clear();
    tc = trig_cnt;
    check_eq("abort_busy", obusy, 0);
    check_eq("abort_osample", osample, 0);
    check_eq("abort_sel", oselect_coefficient, 0);
    repeat (46) @(negedge ctx_clk);
    check_eq("abort_no_trig", trig_cnt - tc, 0);
    drive_sample(16'sd1000, 1'b1);
    check_eq("abort_accept", obusy, 1);
    wait_trig("abort_trig_timeout");
    // Back-to-back: a sample in the strobe cycle is accepted
    drive_sample(-16'sd3000, 1'b1);
    check_eq("b2b_accept", obusy, 1);
    wait_trig("b2b_trig_timeout");
    check_eq("b2b_out", osample, -3000);

    // Enable low for one cycle clears everything
    @(negedge ctx_clk);
    drive_sample(16'sd1000, 1'b1);
    drive_sample(16'sd7, 1'b0);
    check_eq("dis_ovr_set", ooverrun, 1);
    repeat (28) @(negedge ctx_clk);
    etx_en = 1'b0;
    @(negedge ctx_clk);
    etx_en = 1'b1;
    model_clear();
    tc = trig_cnt;
    check_eq("dis_ovr_clr", ooverrun, 0);
    check_eq("dis_busy", obusy, 0);
    check_eq("dis_osample", osample, 0);
    repeat (40) @(negedge ctx_clk);
    check_eq("dis_no_trig", trig_cnt - tc, 0);
    set_coefs(16'sd16384, 16'sd16384);
    send(16'sd0);
    check_eq("dis_line_zero", osample, 0);

    // Moving average: 2000 followed by 64 zeros
    do_reset();
    set_coefs(16'sd16384, 16'sd16384);
    n1000 = 0;
    send(16'sd2000);
    if (osample == 16'sd1000) n1000++;
    for (int i = 0; i < 64; i++) begin
      send(16'sd0);
      if (osample == 16'sd1000) n1000++;
    end
    check_eq("avg_count_1000", n1000, 64);
    check_eq("avg_final", osample, 0);

    // Full-scale window: saturate or wrap
    do_reset();
    set_coefs(16'sd32767, 16'sd32767);
    for (int i = 0; i < 64; i++) send(16'sd32767);
`ifdef TX_FILTER_SAT_EN
    check_eq("fullscale", osample, 32767);
`else
    check_eq("fullscale", osample, -128);
`endif

    repeat (3) @(negedge ctx_clk);
    check_eq("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
